// File: rtl/lfsr2_gen.sv
// lfsr2_gen: 2-bit maximal-length Fibonacci LFSR (x^2 + x + 1).
// Cycles through the non-zero states 01 -> 11 -> 10 with period 3.
// The serial output b is taken directly from state bit 0.
module lfsr2_gen (
  input  logic clk,
  input  logic reset,
  output logic b
);

  // Reset seed. It must be non-zero, because 00 is the lock-up state.
  localparam logic [1:0] SEED = 2'b01;

  logic [1:0] s_q;
  logic [1:0] s_d;

  // Next-state: shift toward bit 1 and feed back the XOR of both taps.
  // A state of 00 maps back to 00. Recovery from it is left to reset.
  always_comb begin
    s_d    = s_q;
    s_d[1] = s_q[0];
    s_d[0] = s_q[1] ^ s_q[0];
  end

  // State register. Reset is asynchronous, so asserting it forces the seed at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= SEED;
    end else begin
      s_q <= s_d;
    end
  end

  // The output comes straight from the register, with no extra stage.
  assign b = s_q[0];

endmodule

// File: tb/tb_lfsr2_gen.sv
// tb_lfsr2_gen: scoreboard-based check of the 2-bit LFSR output stream.
// Expected bits come from the period-3 pattern 1,1,0, indexed by a phase counter.
// They are queued when a clock edge is driven and compared at the following negedge.
module tb_lfsr2_gen;

  logic clk;
  logic reset;
  logic b;

  int tests_run;
  int tests_failed;

  // Phase 0 is state 01, phase 1 is state 11, and phase 2 is state 10.
  logic [2:0] pat;
  int         phase;
  logic       exp_q[$];

  lfsr2_gen dut (
    .clk   (clk),
    .reset (reset),
    .b     (b)
  );

  // Free-running clock with a 10-unit period. Rising edges fall at 5, 15, 25, and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts a comparison and reports a mismatch.
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: b=%b expected %b", tag, obs, exp);
    end else begin
      $display("[TB] %s: b=%b ok", tag, obs);
    end
  endtask

  // Pops the oldest expectation from the scoreboard and compares it against b.
  task automatic compare_head(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty, b=%b", tag, b);
    end else begin
      e = exp_q.pop_front();
      check_bit(tag, b, e);
    end
  endtask

  // Runs one rising edge, queues the bit the edge should produce, then checks it at the negedge.
  task automatic step(input string tag);
    @(posedge clk);
    #1;
    if (reset == 1'b0) phase = (phase + 1) % 3;
    exp_q.push_back(pat[phase]);
    @(negedge clk);
    compare_head(tag);
  endtask

  // Main stimulus sequence.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pat          = 3'b011;
    phase        = 0;
    reset        = 1'b0;

    // Asynchronous assertion while the clock is low.
    #1 reset = 1'b1;
    #1;
    exp_q.push_back(1'b1);
    compare_head("reset_async_initial");

    // Hold reset across several rising edges. The state must not advance.
    for (int i = 0; i < 3; i++) step("reset_hold");

    // Release at a negedge. Expect the bits 1,0,1,1,0.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step("seq_after_reset");

    // Longer run to check the period-3 repetition.
    for (int i = 0; i < 9; i++) step("seq_period");

    // Advance to state 10 (b=0).
    while (phase != 2) step("seek_state10");
    exp_q.push_back(1'b0);
    compare_head("state10_before_reset");

    // Assert reset mid-cycle with no clock edge in between. b must rise at once.
    #2 reset = 1'b1;
    #1;
    phase = 0;
    exp_q.push_back(1'b1);
    compare_head("reset_async_midcycle");

    // Keep reset held over more rising edges.
    for (int i = 0; i < 4; i++) step("reset_hold_mid");

    // Release at a negedge. Expect states 11, 10, 01, giving b = 1, 0, 1.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step("seq_after_midreset");

    // Move off phase 0 so the short pulse has a visible effect.
    while (phase == 0) step("seek_nonseed");

    // Short reset pulse between clock edges.
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    phase = 0;
    exp_q.push_back(1'b1);
    compare_head("short_pulse_seed");
    for (int i = 0; i < 3; i++) step("seq_after_pulse");

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
